clk_div_cfg_seq: RTL and testbench

Configuration sequencer that sits directly upstream of the integer clock divider and drives its ratio, enable and reset inputs. It accepts ratio/enable change requests from the register file over a valid/ready handshake. Each change is applied as a glitch-safe sequence: gate the divider, hold, load the new ratio, pulse the divider reset, settle, then re-enable. Requests that change nothing are acknowledged without disturbing the divider.

---
 rtl/clk_div_cfg_seq_pkg.sv | 20 ++
 rtl/clk_div_guard_timer.sv | 41 ++++
 rtl/clk_div_cfg_seq.sv | 130 +++++++++++++
 tb/tb_clk_div_cfg_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_cfg_seq_pkg.sv
// Shared definitions for the clock-divider configuration sequencer:
// FSM state encoding, guard counter width and the bypass-ratio check.
package clk_div_cfg_seq_pkg;

  localparam int GUARD_CW = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUIESCE = 3'd1,
    ST_LOAD    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_ENABLE  = 3'd4
  } seq_state_t;

  // Ratios 0 and 1 both mean "pass the clock straight through".
  function automatic logic is_bypass(input logic [31:0] ratio);
    return (ratio <= 32'd1);
  endfunction

endpackage

// File: rtl/clk_div_guard_timer.sv
// Guard interval timer: counts GUARD_CYCLES cycles while run is high and
// flags the last one; clr restarts it from zero.
module clk_div_guard_timer
  import clk_div_cfg_seq_pkg::*;
#(
  parameter int GUARD_CYCLES = 4
) (
  input  logic clk,
  input  logic rest,
  input  logic clr,
  input  logic run,
  output logic done
);

  localparam logic [GUARD_CW-1:0] LAST_CNT = GUARD_CW'(GUARD_CYCLES - 1);

  logic [GUARD_CW-1:0] cnt_r;

  // Guard count; saturates on the last guard cycle so it never wraps.
  always_ff @(posedge clk) begin
    if (rest) begin
      cnt_r <= {GUARD_CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {GUARD_CW{1'b0}};
    end else if (run && (cnt_r != LAST_CNT)) begin
      cnt_r <= cnt_r + GUARD_CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Done on the final cycle of the guard interval.
  always_comb begin
    if (run && (cnt_r == LAST_CNT)) begin
      done = 1'b1;
    end else begin
      done = 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_cfg_seq.sv
// Configuration sequencer for the integer clock divider: applies each
// ratio/enable change as gate, hold, load, reset pulse, settle, re-enable.
module clk_div_cfg_seq
  import clk_div_cfg_seq_pkg::*;
#(
  parameter int RATIO_WIDTH  = 8,
  parameter int GUARD_CYCLES = 4,
  parameter int RESET_RATIO  = 1
) (
  input  logic                   clk,
  input  logic                   rest,
  input  logic                   cfg_valid,
  input  logic [RATIO_WIDTH-1:0] cfg_ratio,
  input  logic                   cfg_clk_en,
  output logic                   cfg_ready,
  output logic [RATIO_WIDTH-1:0] div_ratio,
  output logic                   div_clk_en,
  output logic                   div_rst_n,
  output logic                   busy,
  output logic                   bypass
);

  localparam logic [RATIO_WIDTH-1:0] RESET_RATIO_V = RATIO_WIDTH'(RESET_RATIO);
  localparam logic                   RESET_BYPASS  = is_bypass(32'(RESET_RATIO));

  seq_state_t             state_r;
  logic [RATIO_WIDTH-1:0] shadow_ratio_r;
  logic                   shadow_en_r;
  logic                   guard_run_s;
  logic                   guard_clr_s;
  logic                   guard_done_s;

  // Guard timer runs only in the two hold states.
  always_comb begin
    if ((state_r == ST_QUIESCE) || (state_r == ST_SETTLE)) begin
      guard_run_s = 1'b1;
    end else begin
      guard_run_s = 1'b0;
    end
  end

  // Clearing on the exit cycle guarantees a zero count on every state entry.
  always_comb begin
    if (!guard_run_s || guard_done_s) begin
      guard_clr_s = 1'b1;
    end else begin
      guard_clr_s = 1'b0;
    end
  end

  clk_div_guard_timer #(
    .GUARD_CYCLES (GUARD_CYCLES)
  ) u_guard_timer (
    .clk  (clk),
    .rest (rest),
    .clr  (guard_clr_s),
    .run  (guard_run_s),
    .done (guard_done_s)
  );

  // Sequencer FSM; every output is updated on the edge that enters its state.
  always_ff @(posedge clk) begin
    if (rest) begin
      state_r        <= ST_IDLE;
      shadow_ratio_r <= RESET_RATIO_V;
      shadow_en_r    <= 1'b0;
      div_ratio      <= RESET_RATIO_V;
      div_clk_en     <= 1'b0;
      div_rst_n      <= 1'b1;
      bypass         <= RESET_BYPASS;
      cfg_ready      <= 1'b1;
      busy           <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cfg_valid) begin
            shadow_ratio_r <= cfg_ratio;
            shadow_en_r    <= cfg_clk_en;
            // Identical requests are acknowledged without touching the divider.
            if ((cfg_ratio != div_ratio) || (cfg_clk_en != div_clk_en)) begin
              state_r    <= ST_QUIESCE;
              div_clk_en <= 1'b0;
              cfg_ready  <= 1'b0;
              busy       <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_QUIESCE: begin
          if (guard_done_s) begin
            state_r   <= ST_LOAD;
            div_ratio <= shadow_ratio_r;
            div_rst_n <= 1'b0;
            bypass    <= is_bypass(32'(shadow_ratio_r));
          end else begin
            state_r <= ST_QUIESCE;
          end
        end
        ST_LOAD: begin
          state_r   <= ST_SETTLE;
          div_rst_n <= 1'b1;
        end
        ST_SETTLE: begin
          if (guard_done_s) begin
            state_r    <= ST_ENABLE;
            div_clk_en <= shadow_en_r && !is_bypass(32'(shadow_ratio_r));
          end else begin
            state_r <= ST_SETTLE;
          end
        end
        ST_ENABLE: begin
          state_r   <= ST_IDLE;
          cfg_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          div_clk_en <= 1'b0;
          div_rst_n  <= 1'b1;
          cfg_ready  <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_cfg_seq.sv
// Scoreboard bench for clk_div_cfg_seq: a driver issues requests and queues
// the expected outcome, a monitor tracks each accepted request to completion.
module tb_clk_div_cfg_seq;

  localparam int RW = 8;
  localparam int G  = 4;
  localparam int RR = 1;

  logic          clk;
  logic          rest;
  logic          cfg_valid;
  logic [RW-1:0] cfg_ratio;
  logic          cfg_clk_en;
  logic          cfg_ready;
  logic [RW-1:0] div_ratio;
  logic          div_clk_en;
  logic          div_rst_n;
  logic          busy;
  logic          bypass;

  clk_div_cfg_seq #(
    .RATIO_WIDTH  (RW),
    .GUARD_CYCLES (G),
    .RESET_RATIO  (RR)
  ) dut (
    .clk        (clk),
    .rest       (rest),
    .cfg_valid  (cfg_valid),
    .cfg_ratio  (cfg_ratio),
    .cfg_clk_en (cfg_clk_en),
    .cfg_ready  (cfg_ready),
    .div_ratio  (div_ratio),
    .div_clk_en (div_clk_en),
    .div_rst_n  (div_rst_n),
    .busy       (busy),
    .bypass     (bypass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] old_ratio;
    logic [RW-1:0] ratio;
    logic          en;
    logic          byp;
    bit            noop;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model of what the divider currently sees
  logic [RW-1:0] m_ratio;
  logic          m_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor state
  exp_t cur;
  bit   in_txn = 1'b0;
  int   cyc, busy_cnt, rst_cnt, rst_pos;
  bit   ratio_bad, en_bad;

  always @(negedge clk) begin
    if (rest) begin
      in_txn = 1'b0;
      sb.delete();
    end else begin
      if (in_txn) begin
        cyc++;
        if (busy) busy_cnt++;
        if (!div_rst_n) begin
          rst_cnt++;
          rst_pos = cyc;
        end
        if ((cyc <= G) && (div_ratio !== cur.old_ratio)) ratio_bad = 1'b1;
        if ((cyc > G) && (div_ratio !== cur.ratio)) ratio_bad = 1'b1;
        if (!cur.noop && (cyc <= 2*G+1) && (div_clk_en !== 1'b0)) en_bad = 1'b1;
        if (!busy) begin
          chk("final_ratio", 32'(div_ratio), 32'(cur.ratio));
          chk("final_clk_en", 32'(div_clk_en), 32'(cur.en));
          chk("final_bypass", 32'(bypass), 32'(cur.byp));
          chk("ready_idle", 32'(cfg_ready), 32'd1);
          chk("busy_cycles", 32'(busy_cnt), cur.noop ? 32'd0 : 32'(2*G+2));
          chk("rst_pulses", 32'(rst_cnt), cur.noop ? 32'd0 : 32'd1);
          if (!cur.noop) chk("rst_cycle", 32'(rst_pos), 32'(G+1));
          chk("ratio_timing", 32'(ratio_bad), 32'd0);
          chk("en_gating", 32'(en_bad), 32'd0);
          in_txn = 1'b0;
        end else if (cyc > 200) begin
          chk("txn_timeout", 32'(cyc), 32'(2*G+3));
          in_txn = 1'b0;
        end
      end
      if (!in_txn && cfg_valid && cfg_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_accept", 32'(sb.size()), 32'd1);
        end else begin
          cur       = sb.pop_front();
          in_txn    = 1'b1;
          cyc       = 0;
          busy_cnt  = 0;
          rst_cnt   = 0;
          rst_pos   = 0;
          ratio_bad = 1'b0;
          en_bad    = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [RW-1:0] r, input logic e);
    exp_t x;
    int   n;
    x.old_ratio = m_ratio;
    x.noop      = (r == m_ratio) && (e == m_en);
    if (!x.noop) begin
      m_ratio = r;
      m_en    = e && (r > 1);
    end
    x.ratio = m_ratio;
    x.en    = m_en;
    x.byp   = (m_ratio <= 1);
    sb.push_back(x);
    cfg_valid  = 1'b1;
    cfg_ratio  = r;
    cfg_clk_en = e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cfg_ready && n < 300);
    if (!cfg_ready) chk("accept_timeout", 32'(n), 32'(2*G+2));
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((in_txn || sb.size() != 0) && n < 300);
    if (in_txn || sb.size() != 0) chk("drain_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ratio"}, 32'(div_ratio), 32'(RR));
    chk({tag, "_clk_en"}, 32'(div_clk_en), 32'd0);
    chk({tag, "_rst_n"}, 32'(div_rst_n), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    chk({tag, "_bypass"}, 32'(bypass), 32'(RR <= 1));
  endtask

  initial begin
    logic [RW-1:0] r;
    logic          e;
    rest       = 1'b1;
    cfg_valid  = 1'b0;
    cfg_ratio  = '0;
    cfg_clk_en = 1'b0;
    m_ratio    = RW'(RR);
    m_en       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rest = 1'b0;
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1;

    // Directed sequence from the plan; the ratio-5 request is held while busy
    send(8'd8, 1'b1);
    drain();
    send(8'd8, 1'b1);
    drain();
    send(8'd1, 1'b1);
    send(8'd5, 1'b1);
    drain();

    // Randomized requests, roughly a quarter repeating the applied setting
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = m_ratio;
        e = m_en;
      end else begin
        r = RW'($urandom_range(0, 12));
        e = 1'($urandom_range(0, 1));
      end
      send(r, e);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain();

    // Reset in the first SETTLE cycle
    r = (m_ratio == 8'd9) ? 8'd10 : 8'd9;
    send(r, 1'b1);
    repeat (G + 1) @(posedge clk);
    #1;
    chk("pre_reset_busy", 32'(busy), 32'd1);
    chk("pre_reset_ratio", 32'(div_ratio), 32'(r));
    rest = 1'b1;
    @(posedge clk);
    #1;
    rest    = 1'b0;
    m_ratio = RW'(RR);
    m_en    = 1'b0;
    @(negedge clk);
    check_reset_state("mid_reset");
    @(posedge clk);
    #1;

    send(8'd6, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
